// File: rtl/emu_time_pkg.sv
// emu_time_pkg: shared state/command encodings and default widths for the emulation time controller.
package emu_time_pkg;
    localparam int N_REQ_DEF      = 4;
    localparam int DT_WIDTH_DEF   = 24;
    localparam int TIME_WIDTH_DEF = 40;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_STOP     = 2'd0,
        OP_RUN      = 2'd1,
        OP_STEP     = 2'd2,
        OP_SET_STOP = 2'd3
    } op_t;
endpackage

// File: rtl/dt_min_tree.sv
// dt_min_tree: unsigned minimum over all timestep request lanes; a zero lane places no constraint.
module dt_min_tree
    import emu_time_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    output logic [DT_WIDTH-1:0]       dt_min
);
    always_comb begin
        dt_min = '1;
        for (int i = 0; i < N_REQ; i++)
            if (dt_req[i*DT_WIDTH +: DT_WIDTH] != '0 && dt_req[i*DT_WIDTH +: DT_WIDTH] < dt_min)
                dt_min = dt_req[i*DT_WIDTH +: DT_WIDTH];
    end
endmodule

// File: rtl/emu_time_ctrl.sv
// emu_time_ctrl: run/step/halt control of an emulated model, issuing clock enables and timesteps
// bounded by the requesters' limits and an optional stop time.
module emu_time_ctrl
    import emu_time_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DT_WIDTH   = DT_WIDTH_DEF,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [TIME_WIDTH-1:0]     cmd_arg,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    output logic                      emu_ce,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      stop_hit,
    output logic [1:0]                state_o
);
    state_t                state, state_nxt;
    logic [DT_WIDTH-1:0]   dt_min, dt_min_reg, dt_app;
    logic [TIME_WIDTH-1:0] stop_time, remain;
    logic [TIME_WIDTH:0]   sum;
    logic                  stop_en, acc, fire, at_stop;

    dt_min_tree #(.N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH)) u_min (
        .dt_req (dt_req),
        .dt_min (dt_min)
    );

    assign cmd_ready = state != S_STEP;
    assign acc       = cmd_valid && cmd_ready;
    assign remain    = stop_time > emu_time ? stop_time - emu_time : '0;
    assign dt_app    = stop_en && remain < TIME_WIDTH'(dt_min_reg) ? remain[DT_WIDTH-1:0] : dt_min_reg;
    assign sum       = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt_app);
    // Covers both landing exactly on the stop time and already being at/past it (dt_app = 0).
    assign at_stop   = stop_en && sum >= {1'b0, stop_time};
    assign fire      = (state == S_RUN || state == S_STEP) && dt_app != '0;
    assign stop_hit  = state == S_HALT;
    assign state_o   = state;

    always_comb begin
        state_nxt = state;
        if (state == S_STEP)
            state_nxt = S_IDLE;
        else if (state == S_RUN && at_stop)
            state_nxt = S_HALT;
        if (acc) begin
            if (cmd_op == OP_STOP)
                state_nxt = S_IDLE;
            else if (cmd_op == OP_RUN && (state == S_IDLE || (state == S_HALT && stop_time > emu_time)))
                state_nxt = S_RUN;
            else if (cmd_op == OP_STEP && state == S_IDLE)
                state_nxt = S_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            emu_ce     <= 1'b0;
            emu_dt     <= '0;
            emu_time   <= '0;
            stop_time  <= '0;
            stop_en    <= 1'b0;
            dt_min_reg <= '1;
        end else begin
            state      <= state_nxt;
            dt_min_reg <= dt_min;
            emu_ce     <= fire;
            emu_dt     <= fire ? dt_app : '0;
            if (fire)
                emu_time <= sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
            if (acc && cmd_op == OP_SET_STOP) begin
                stop_time <= cmd_arg;
                stop_en   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_emu_time_ctrl.sv
// tb_emu_time_ctrl: directed scenarios plus randomized commands, checked every cycle against a behavioural model.
module tb_emu_time_ctrl;
    localparam int NR = 4;
    localparam int DW = 24;
    // Narrow time width so saturation is reachable in a few dozen maximum-size steps.
    localparam int TW = 28;
    localparam longint DMAX = (64'd1 << DW) - 1;
    localparam longint TMAX = (64'd1 << TW) - 1;

    logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, emu_ce, stop_hit;
    logic [1:0]    cmd_op = '0, state_o;
    logic [TW-1:0] cmd_arg = '0, emu_time;
    logic [NR*DW-1:0] dt_req = '0;
    logic [DW-1:0] emu_dt;

    int checks = 0, errors = 0;
    int mst;
    longint mt, mstop, mdmin, mdt;
    bit msen, mce;

    emu_time_ctrl #(.N_REQ(NR), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .dt_req(dt_req), .emu_ce(emu_ce), .emu_dt(emu_dt),
        .emu_time(emu_time), .stop_hit(stop_hit), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mst = 0; mt = 0; mstop = 0; msen = 0; mdmin = DMAX; mce = 0; mdt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 64'(state_o), 64'(mst));
        chk({tag, ".ce"}, 64'(emu_ce), 64'(mce));
        chk({tag, ".dt"}, 64'(emu_dt), mdt);
        chk({tag, ".time"}, 64'(emu_time), mt);
        chk({tag, ".stop_hit"}, 64'(stop_hit), 64'(mst == 3));
        chk({tag, ".ready"}, 64'(cmd_ready), 64'(mst != 2));
    endtask

    // Expected effect of the coming clock edge, from the current inputs and model state.
    task automatic predict();
        longint lim, app, lane, dmn;
        int ns;
        bit acc, go;
        acc = cmd_valid && mst != 2;
        lim = msen ? (mstop > mt ? mstop - mt : 0) : DMAX;
        app = mdmin < lim ? mdmin : lim;
        go = (mst == 1 || mst == 2) && app > 0;
        ns = (mst == 2) ? 0 : mst;
        if (mst == 1 && msen && (mt + app == mstop || mstop <= mt)) ns = 3;
        if (acc) begin
            if (cmd_op == 2'd0) ns = 0;
            else if (cmd_op == 2'd1 && (mst == 0 || (mst == 3 && mstop > mt))) ns = 1;
            else if (cmd_op == 2'd2 && mst == 0) ns = 2;
        end
        dmn = DMAX;
        for (int i = 0; i < NR; i++) begin
            lane = longint'(dt_req[i*DW +: DW]);
            if (lane != 0 && lane < dmn) dmn = lane;
        end
        if (acc && cmd_op == 2'd3) begin
            mstop = longint'(cmd_arg);
            msen = 1;
        end
        if (go) mt = (mt + app > TMAX) ? TMAX : mt + app;
        mce = go;
        mdt = go ? app : 0;
        mst = ns;
        mdmin = dmn;
    endtask

    task automatic cycle(input bit v, input int op, input longint arg);
        cmd_valid = v;
        cmd_op = 2'(op);
        cmd_arg = TW'(arg);
        predict();
        @(posedge clk);
        #1;
        check_all("cyc");
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_all(input longint v);
        for (int i = 0; i < NR; i++) dt_req[i*DW +: DW] = DW'(v);
    endtask

    initial begin
        int n;
        longint q[$];
        longint a;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Free run with one unconstrained lane.
        dt_req = {DW'(100), DW'(50), DW'(0), DW'(200)};
        idle(2);
        cycle(1, 1, 0);
        n = 0;
        for (int k = 0; k < 40 && n < 10; k++) begin
            idle(1);
            if (emu_ce) n++;
        end
        chk("run.enables", 64'(n), 64'd10);
        chk("run.time500", 64'(emu_time), 64'd500);
        chk("run.dt50", 64'(emu_dt), 64'd50);

        // Reset while running, then restart from zero.
        do_reset("rst_run");
        cycle(1, 1, 0);
        idle(3);
        chk("restart.time", 64'(emu_time), 64'd150);

        // Stop time 120 with dt 50.
        do_reset("rst2");
        set_all(50);
        cycle(1, 3, 120);
        cycle(1, 1, 0);
        for (int k = 0; k < 20 && !stop_hit; k++) begin
            idle(1);
            if (emu_ce) q.push_back(longint'(emu_dt));
        end
        chk("halt.nsteps", 64'(q.size()), 64'd3);
        chk("halt.s0", q[0], 64'd50);
        chk("halt.s1", q[1], 64'd50);
        chk("halt.s2", q[2], 64'd20);
        chk("halt.time", 64'(emu_time), 64'd120);
        idle(2);
        chk("halt.ce_off", 64'(emu_ce), 64'd0);
        chk("halt.stop_hit", 64'(stop_hit), 64'd1);
        cycle(1, 1, 0);
        chk("halt.rerun_stays", 64'(state_o), 64'd3);
        cycle(1, 3, 200);
        cycle(1, 1, 0);
        chk("halt.resume", 64'(state_o), 64'd1);
        for (int k = 0; k < 20 && !stop_hit; k++) idle(1);
        chk("halt2.time", 64'(emu_time), 64'd200);
        chk("halt2.state", 64'(state_o), 64'd3);

        // Single step.
        do_reset("rst3");
        set_all(7);
        idle(1);
        cycle(1, 2, 0);
        chk("step.ready_low", 64'(cmd_ready), 64'd0);
        cycle(1, 1, 0);
        chk("step.ce", 64'(emu_ce), 64'd1);
        chk("step.time", 64'(emu_time), 64'd7);
        chk("step.idle", 64'(state_o), 64'd0);
        chk("step.ready_back", 64'(cmd_ready), 64'd1);
        idle(2);
        chk("step.one_pulse", 64'(emu_ce), 64'd0);

        // All lanes unconstrained for one cycle, then saturate.
        set_all(0);
        cycle(1, 1, 0);
        set_all(7);
        idle(1);
        chk("max.dt", 64'(emu_dt), DMAX);
        set_all(0);
        for (int k = 0; k < 40 && emu_time != TW'(TMAX); k++) idle(1);
        idle(2);
        chk("sat.time", 64'(emu_time), TMAX);
        chk("sat.ce", 64'(emu_ce), 64'd1);

        // Randomized commands and timestep limits.
        do_reset("rst4");
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 199) do_reset("rst_rand");
            if ($urandom_range(0, 5) == 0)
                for (int j = 0; j < NR; j++)
                    dt_req[j*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom_range(1, 120));
            a = mt + longint'($urandom_range(0, 300)) - 60;
            if (a < 0) a = 0;
            cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/emu_time_ctrl.md
EMU_TIME_CTRL -- requirements
Module: emu_time_ctrl

Interface
REQ-001 Parameter N_REQ, default 4: number of dt requesters (1..16).
REQ-002 Parameter DT_WIDTH, default 24: width of each timestep request and of emu_dt.
REQ-003 Parameter TIME_WIDTH, default 40: width of emulated time and stop time.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 cmd_valid  input  1: command offered.
REQ-007 cmd_ready  output  1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_op  input  2: 0=STOP, 1=RUN, 2=STEP, 3=SET_STOP.
REQ-009 cmd_arg  input  TIME_WIDTH: stop time for SET_STOP; ignored otherwise.
REQ-010 dt_req  input  N_REQ*DT_WIDTH: packed per-requester maximum timestep; 0 means "no constraint".
REQ-011 emu_ce  output  1: emulator clock enable; model state advances only when high.
REQ-012 emu_dt  output  DT_WIDTH: timestep applied in the current emu_ce cycle.
REQ-013 emu_time  output  TIME_WIDTH: accumulated emulated time.
REQ-014 stop_hit  output  1: high while in HALT.
REQ-015 state_o  output  2: current state encoding (IDLE=0, RUN=1, STEP=2, HALT=3).

Function
REQ-016 FSM states IDLE, RUN, STEP, HALT; STEP is a one-enable state.
REQ-017 cmd_ready shall be high in IDLE, RUN and HALT, and low in STEP.
REQ-018 Accepted RUN: IDLE->RUN, HALT->RUN only if stop_time > emu_time, else HALT retained.
REQ-019 Accepted STOP: any state except STEP -> IDLE next cycle.
REQ-020 Accepted STEP in IDLE -> STEP; STEP returns to IDLE after exactly one emu_ce cycle; STEP in RUN/HALT is accepted and ignored.
REQ-021 Accepted SET_STOP loads stop_time and sets stop_en in any state, without changing state.
REQ-022 dt_min = unsigned minimum over all dt_req lanes, with 0 lanes treated as 2^DT_WIDTH-1.
REQ-023 dt_min shall be registered once (one-cycle pipeline) before use.
REQ-024 If stop_en, dt_app = min(dt_min_reg, stop_time - emu_time), else dt_app = dt_min_reg.
REQ-025 emu_ce and emu_dt shall be registered: high and dt_app in every cycle spent in RUN or STEP when dt_app > 0; otherwise emu_ce=0 and emu_dt=0.
REQ-026 emu_time shall increase by emu_dt on each cycle with emu_ce=1, saturating at 2^TIME_WIDTH-1.
REQ-027 In RUN, when stop_en and emu_time+emu_dt == stop_time, the FSM shall enter HALT in the same edge that applies the final step; no further emu_ce.
REQ-028 In RUN, dt_app = 0 while stop_en and emu_time == stop_time shall force HALT.
REQ-029 SET_STOP accepted in the same cycle as a HALT transition: the new stop_time applies from the next cycle; HALT still entered.
REQ-030 SET_STOP with cmd_arg <= emu_time while in RUN causes HALT on the next cycle without a step.

Reset
REQ-031 On rst: state=IDLE, emu_ce=0, emu_dt=0, emu_time=0, stop_time=0, stop_en=0, dt_min_reg=all ones, stop_hit=0.
REQ-032 Reset asserted mid-RUN shall drop emu_ce asynchronously with no partial time update.

Structure
REQ-033 Package emu_time_pkg shall hold the state enum, the cmd_op enum and the default widths.
REQ-034 The N_REQ minimum tree shall be the sub-module dt_min_tree (combinational, parameterised by N_REQ and DT_WIDTH).

Verification
REQ-035 RUN with dt_req={100,50,0,200}, no stop: emu_dt=50 per cycle from the second cycle after acceptance; emu_time=500 after 10 enables.
REQ-036 SET_STOP 120, then RUN with all dt=50: steps 50,50,20; emu_time=120; stop_hit=1; emu_ce=0 thereafter.
REQ-037 STEP in IDLE with dt=7: exactly one emu_ce pulse, emu_time=7, return to IDLE, cmd_ready low for one cycle.
REQ-038 All dt_req=0 for one cycle: emu_dt=2^24-1 on the following step, and emu_time saturates at 2^40-1 on repeated steps near the top.
REQ-039 rst pulsed during RUN: emu_ce low immediately, all outputs at reset values, and RUN after release restarts from emu_time=0.
REQ-040 In HALT at 120, RUN without SET_STOP stays in HALT; SET_STOP 200 then RUN: 80 more time units, then HALT.
